spwm_comparador_dt: RTL and testbench

- Downstream stage of the SPWM carrier/sample counter. Consumes the carrier index `selection` and the sine-sample index `q_onda`.
- Looks up the sine sample and scales it to the carrier peak selected by `modo`. Compares the scaled reference against the carrier.
- Drives a complementary high/low gate pair with programmable dead time. Output feeds the half-bridge gate drivers.

---
 rtl/spwm_pkg.sv | 61 ++++++
 rtl/spwm_seno_lut.sv | 21 ++
 rtl/spwm_comparador_dt.sv | 171 +++++++++++++++++
 tb/tb_spwm_comparador_dt.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spwm_pkg.sv
// Shared constants for the SPWM comparator: carrier peaks, mode codes,
// FSM state encoding and the quarter-wave sine table used by the ROM.
package spwm_pkg;

  localparam logic [16:0] PEAK_MODO0 = 17'd3839;
  localparam logic [16:0] PEAK_MODO1 = 17'd15359;

  localparam logic [1:0] MODO_0 = 2'b00;
  localparam logic [1:0] MODO_1 = 2'b01;

  localparam int LUT_DEPTH = 256;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_DT_HL = 3'd1;
  localparam state_t ST_LOW   = 3'd2;
  localparam state_t ST_DT_LH = 3'd3;
  localparam state_t ST_HIGH  = 3'd4;

  // round(127.5 + 127.5*sin(2*pi*j/256)) for the first quarter, j = 0..64
  function automatic logic [7:0] seno_quarter(input logic [6:0] j);
    logic [7:0] v;
    case (j)
      7'd0:  v = 8'd128;  7'd1:  v = 8'd131;  7'd2:  v = 8'd134;  7'd3:  v = 8'd137;
      7'd4:  v = 8'd140;  7'd5:  v = 8'd143;  7'd6:  v = 8'd146;  7'd7:  v = 8'd149;
      7'd8:  v = 8'd152;  7'd9:  v = 8'd155;  7'd10: v = 8'd158;  7'd11: v = 8'd162;
      7'd12: v = 8'd165;  7'd13: v = 8'd167;  7'd14: v = 8'd170;  7'd15: v = 8'd173;
      7'd16: v = 8'd176;  7'd17: v = 8'd179;  7'd18: v = 8'd182;  7'd19: v = 8'd185;
      7'd20: v = 8'd188;  7'd21: v = 8'd190;  7'd22: v = 8'd193;  7'd23: v = 8'd196;
      7'd24: v = 8'd198;  7'd25: v = 8'd201;  7'd26: v = 8'd203;  7'd27: v = 8'd206;
      7'd28: v = 8'd208;  7'd29: v = 8'd211;  7'd30: v = 8'd213;  7'd31: v = 8'd215;
      7'd32: v = 8'd218;  7'd33: v = 8'd220;  7'd34: v = 8'd222;  7'd35: v = 8'd224;
      7'd36: v = 8'd226;  7'd37: v = 8'd228;  7'd38: v = 8'd230;  7'd39: v = 8'd232;
      7'd40: v = 8'd234;  7'd41: v = 8'd235;  7'd42: v = 8'd237;  7'd43: v = 8'd238;
      7'd44: v = 8'd240;  7'd45: v = 8'd241;  7'd46: v = 8'd243;  7'd47: v = 8'd244;
      7'd48: v = 8'd245;  7'd49: v = 8'd246;  7'd50: v = 8'd248;  7'd51: v = 8'd249;
      7'd52: v = 8'd250;  7'd53: v = 8'd250;  7'd54: v = 8'd251;  7'd55: v = 8'd252;
      7'd56: v = 8'd253;  7'd57: v = 8'd253;  7'd58: v = 8'd254;  7'd59: v = 8'd254;
      7'd60: v = 8'd254;  7'd61: v = 8'd255;  7'd62: v = 8'd255;  7'd63: v = 8'd255;
      7'd64: v = 8'd255;
      default: v = 8'd128;
    endcase
    return v;
  endfunction

  // Full-wave sample from quarter-wave symmetry; the negative half mirrors around 255.
  function automatic logic [7:0] seno_val(input logic [7:0] k);
    logic [7:0] v;
    if (k <= 8'd64) begin
      v = seno_quarter(k[6:0]);
    end else if (k <= 8'd128) begin
      v = seno_quarter(7'(8'd128 - k));
    end else if (k <= 8'd192) begin
      v = 8'd255 - seno_quarter(7'(k - 8'd128));
    end else begin
      v = 8'd255 - seno_quarter(7'(9'd256 - {1'b0, k}));
    end
    return v;
  endfunction

endpackage

// File: rtl/spwm_seno_lut.sv
// Synchronous-read sine ROM, one cycle of latency, data register not reset.
module spwm_seno_lut
  import spwm_pkg::*;
#(
  parameter int AW = $clog2(LUT_DEPTH)
) (
  input  logic          clk3,
  input  logic [AW-1:0] i_addr,
  output logic [7:0]    o_data
);

  logic [7:0] r_data;

  // ROM read register
  always_ff @(posedge clk3) begin
    r_data <= seno_val(8'(i_addr));
  end

  assign o_data = r_data;

endmodule

// File: rtl/spwm_comparador_dt.sv
// SPWM comparator: scales the sine sample to the selected carrier peak,
// compares it to the carrier and drives a complementary gate pair with dead time.
module spwm_comparador_dt
  import spwm_pkg::*;
#(
  parameter int LUT_AW = 8,
  parameter int DEAD   = 8,
  parameter int CNT_W  = 17
) (
  input  logic             clk3,
  input  logic             rst,
  input  logic [1:0]       modo,
  input  logic [CNT_W-1:0] selection,
  input  logic [CNT_W-1:0] q_onda,
  input  logic             en,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic [CNT_W-1:0] ref_out,
  output logic             cmp_out
);

  localparam logic [7:0] DT_LOAD = 8'(DEAD - 1);

  logic [7:0]       w_lut;
  logic [CNT_W-1:0] r_sel_d1;
  logic [CNT_W-1:0] r_sel_d2;
  logic [CNT_W-1:0] r_ref;
  logic [1:0]       r_modo_d1;
  logic             r_cmp;
  logic [13:0]      w_peak1;
  logic [21:0]      w_prod;
  logic [CNT_W-1:0] w_ref;
  logic             w_modo_ok;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic             r_pwm_h;
  logic             r_pwm_l;
  logic             w_pwm_h_nxt;
  logic             w_pwm_l_nxt;
  logic             w_unused;

  assign w_unused = ^{q_onda[CNT_W-1:LUT_AW], w_prod[7:0]};

  spwm_seno_lut #(.AW(LUT_AW)) u_lut (
    .clk3   (clk3),
    .i_addr (q_onda[LUT_AW-1:0]),
    .o_data (w_lut)
  );

  // Scale the sample to peak+1; max 255*15360 >> 8 = 15300, so no saturation
  always_comb begin
    w_peak1 = 14'(PEAK_MODO0 + 17'd1);
    if (r_modo_d1 == MODO_1) begin
      w_peak1 = 14'(PEAK_MODO1 + 17'd1);
    end else begin
      w_peak1 = 14'(PEAK_MODO0 + 17'd1);
    end
    w_prod = {14'd0, w_lut} * {8'd0, w_peak1};
    w_ref  = CNT_W'(w_prod[21:8]);
  end

  // Three-stage datapath: lookup, scale, compare
  always_ff @(posedge clk3 or posedge rst) begin
    if (rst) begin
      r_sel_d1  <= '0;
      r_modo_d1 <= 2'b00;
      r_ref     <= '0;
      r_sel_d2  <= '0;
      r_cmp     <= 1'b0;
    end else begin
      r_sel_d1  <= selection;
      r_modo_d1 <= modo;
      r_ref     <= w_ref;
      r_sel_d2  <= r_sel_d1;
      r_cmp     <= (r_ref > r_sel_d2);
    end
  end

  assign w_modo_ok = (modo == MODO_0) || (modo == MODO_1);

  // State, dead counter and gate outputs
  always_ff @(posedge clk3 or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_pwm_h <= 1'b0;
      r_pwm_l <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pwm_h <= w_pwm_h_nxt;
      r_pwm_l <= w_pwm_l_nxt;
    end
  end

  // Next state; the dead-time exit samples the live compare so short pulses are absorbed
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!en || !w_modo_ok) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_DT_LH;
          w_cnt_nxt   = DT_LOAD;
        end
        ST_HIGH: begin
          if (!r_cmp) begin
            w_state_nxt = ST_DT_HL;
            w_cnt_nxt   = DT_LOAD;
          end else begin
            w_state_nxt = ST_HIGH;
            w_cnt_nxt   = r_cnt;
          end
        end
        ST_LOW: begin
          if (r_cmp) begin
            w_state_nxt = ST_DT_LH;
            w_cnt_nxt   = DT_LOAD;
          end else begin
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = r_cnt;
          end
        end
        ST_DT_HL, ST_DT_LH: begin
          if (r_cnt != 8'd0) begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt - 8'd1;
          end else begin
            w_state_nxt = r_cmp ? ST_HIGH : ST_LOW;
            w_cnt_nxt   = 8'd0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  // Gate decode of the state being entered, so registered outputs track the state register
  always_comb begin
    w_pwm_h_nxt = 1'b0;
    w_pwm_l_nxt = 1'b0;
    case (w_state_nxt)
      ST_HIGH: begin
        w_pwm_h_nxt = 1'b1;
        w_pwm_l_nxt = 1'b0;
      end
      ST_LOW: begin
        w_pwm_h_nxt = 1'b0;
        w_pwm_l_nxt = 1'b1;
      end
      default: begin
        w_pwm_h_nxt = 1'b0;
        w_pwm_l_nxt = 1'b0;
      end
    endcase
  end

  assign pwm_h   = r_pwm_h;
  assign pwm_l   = r_pwm_l;
  assign ref_out = r_ref;
  assign cmp_out = r_cmp;

endmodule

// File: tb/tb_spwm_comparador_dt.sv
// Scoreboard bench for spwm_comparador_dt: directed stimulus queues expected
// output values per cycle; an independent monitor pops and compares them.
module tb_spwm_comparador_dt;

  localparam int PH = 0;
  localparam int PL = 1;
  localparam int RF = 2;
  localparam int CM = 3;

  logic        clk3 = 1'b0;
  logic        rst;
  logic [1:0]  modo;
  logic [16:0] sel;
  logic [16:0] q;
  logic        en;
  logic        pwm_h;
  logic        pwm_l;
  logic [16:0] ref_out;
  logic        cmp_out;

  typedef struct {
    int          tgt;
    int          id;
    logic [16:0] exp;
    string       nm;
  } chk_t;

  chk_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_inv = 0;
  logic [16:0] mon_act;
  event        chk_now;

  spwm_comparador_dt #(.LUT_AW(8), .DEAD(8), .CNT_W(17)) dut (
    .clk3      (clk3),
    .rst       (rst),
    .modo      (modo),
    .selection (sel),
    .q_onda    (q),
    .en        (en),
    .pwm_h     (pwm_h),
    .pwm_l     (pwm_l),
    .ref_out   (ref_out),
    .cmp_out   (cmp_out)
  );

  always #5 clk3 = ~clk3;

  always @(posedge clk3) cyc <= cyc + 1;

  function automatic logic [16:0] dut_val(input int id);
    case (id)
      PH:      return {16'd0, pwm_h};
      PL:      return {16'd0, pwm_l};
      RF:      return ref_out;
      default: return {16'd0, cmp_out};
    endcase
  endfunction

  // Monitor: invariant every cycle, then retire every check due now
  always begin
    @(negedge clk3 or chk_now);
    if (pwm_h && pwm_l) n_inv++;
    for (int k = 0; k < sb.size(); ) begin
      if (sb[k].tgt == -1 || sb[k].tgt == cyc) begin
        n_chk++;
        mon_act = dut_val(sb[k].id);
        if (mon_act === sb[k].exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", sb[k].nm, mon_act, sb[k].exp, cyc);
        sb.delete(k);
      end else if (sb[k].tgt < cyc) begin
        n_chk++;
        $display("FAIL %s: check due at cycle %0d never sampled, now %0d", sb[k].nm, sb[k].tgt, cyc);
        sb.delete(k);
      end else begin
        k++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk3);
  endtask

  task automatic exp_at(input int t, input int id, input int v, input string nm);
    chk_t c;
    c.tgt = t;
    c.id  = id;
    c.exp = 17'(v);
    c.nm  = nm;
    sb.push_back(c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c0, c1, c2, c3, c4, c5, c6, c7, c8, c9;
    rst = 1'b1; en = 1'b0; modo = 2'b00; sel = 17'd0; q = 17'd0;

    // reset state
    tick(2);
    exp_at(cyc + 1, PH, 0, "rst_pwm_h");
    exp_at(cyc + 1, PL, 0, "rst_pwm_l");
    exp_at(cyc + 1, RF, 0, "rst_ref");
    exp_at(cyc + 1, CM, 0, "rst_cmp");
    tick();
    rst = 1'b0;
    tick();
    exp_at(cyc + 1, PH, 0, "idle_pwm_h");
    exp_at(cyc + 1, PL, 0, "idle_pwm_l");
    tick(2);

    // mode 00, sine peak, carrier ramps down 3839..0
    c0 = cyc;
    modo = 2'b00; q = 17'd64; en = 1'b1; sel = 17'd3839;
    exp_at(c0 + 2, RF, 3825, "m0_ref_peak");
    for (int k = 1; k <= 8; k++) begin
      exp_at(c0 + k, PH, 0, "m0_start_off_h");
      exp_at(c0 + k, PL, 0, "m0_start_off_l");
    end
    exp_at(c0 + 9, PL, 1, "m0_first_low");
    exp_at(c0 + 17, CM, 0, "m0_cmp_at_3825");
    exp_at(c0 + 18, CM, 1, "m0_cmp_at_3824");
    exp_at(c0 + 18, PL, 1, "m0_low_hold");
    for (int k = 19; k <= 26; k++) begin
      exp_at(c0 + k, PH, 0, "m0_dt_lh_h");
      exp_at(c0 + k, PL, 0, "m0_dt_lh_l");
    end
    exp_at(c0 + 27, PH, 1, "m0_high");
    exp_at(c0 + 27, PL, 0, "m0_high_l");
    for (int i = 1; i <= 3839; i++) begin
      tick();
      sel = 17'(3839 - i);
    end
    exp_at(cyc + 4, PH, 1, "m0_end_high");
    exp_at(cyc + 4, CM, 1, "m0_end_cmp");
    tick(4);

    // asynchronous reset in HIGH, no clock edge
    #1;
    exp_at(-1, PH, 1, "pre_rst_high");
    ->chk_now;
    #1 rst = 1'b1;
    #1;
    exp_at(-1, PH, 0, "async_rst_h");
    exp_at(-1, PL, 0, "async_rst_l");
    exp_at(-1, RF, 0, "async_rst_ref");
    exp_at(-1, CM, 0, "async_rst_cmp");
    ->chk_now;
    en = 1'b0;
    tick(2);
    rst = 1'b0;
    tick();
    exp_at(cyc + 1, PH, 0, "post_rst_h");
    exp_at(cyc + 1, PL, 0, "post_rst_l");
    tick(2);

    // mode 01, sine midscale: boundary 7680/7679
    c1 = cyc;
    modo = 2'b01; q = 17'd0; en = 1'b1; sel = 17'd7690;
    exp_at(c1 + 2, RF, 7680, "m1_ref_mid");
    exp_at(c1 + 9, PL, 1, "m1_first_low");
    exp_at(c1 + 13, CM, 0, "m1_cmp_at_7680");
    exp_at(c1 + 14, CM, 1, "m1_cmp_at_7679");
    exp_at(c1 + 14, PL, 1, "m1_low_hold");
    exp_at(c1 + 15, PL, 0, "m1_low_off");
    exp_at(c1 + 22, PH, 0, "m1_dt_last");
    exp_at(c1 + 23, PH, 1, "m1_high");
    for (int i = 1; i <= 20; i++) begin
      tick();
      sel = 17'(7690 - i);
    end
    tick(4);

    // compare 1->0: exactly 8 dead cycles before low side
    c2 = cyc;
    sel = 17'd7690;
    exp_at(c2 + 2, CM, 1, "dt_hl_cmp_before");
    exp_at(c2 + 3, CM, 0, "dt_hl_cmp_after");
    exp_at(c2 + 3, PH, 1, "dt_hl_high_last");
    for (int k = 4; k <= 11; k++) begin
      exp_at(c2 + k, PH, 0, "dt_hl_off_h");
      exp_at(c2 + k, PL, 0, "dt_hl_off_l");
    end
    exp_at(c2 + 12, PL, 1, "dt_hl_low");
    tick(14);

    // back to HIGH, then a 3-cycle low pulse on the compare
    c3 = cyc;
    sel = 17'd7670;
    exp_at(c3 + 12, PH, 1, "sp_setup_high");
    tick(15);
    c4 = cyc;
    sel = 17'd7690;
    exp_at(c4 + 3, CM, 0, "sp_cmp_low0");
    exp_at(c4 + 5, CM, 0, "sp_cmp_low2");
    exp_at(c4 + 6, CM, 1, "sp_cmp_back");
    exp_at(c4 + 3, PH, 1, "sp_high_last");
    exp_at(c4 + 4, PH, 0, "sp_dt_entered");
    for (int k = 4; k <= 12; k++) exp_at(c4 + k, PL, 0, "sp_no_low");
    exp_at(c4 + 11, PH, 0, "sp_dt_last");
    exp_at(c4 + 12, PH, 1, "sp_high_again");
    tick(3);
    sel = 17'd7670;
    tick(14);

    // sine minimum: ref 0, strict compare against 0 keeps low side on
    c5 = cyc;
    q = 17'd192; sel = 17'd0;
    exp_at(c5 + 2, RF, 0, "min_ref");
    exp_at(c5 + 3, CM, 0, "min_cmp_strict");
    exp_at(c5 + 3, PH, 1, "min_high_last");
    exp_at(c5 + 4, PH, 0, "min_dt");
    exp_at(c5 + 12, PL, 1, "min_low");
    for (int k = 13; k <= 30; k++) begin
      exp_at(c5 + k, PL, 1, "min_low_hold");
      exp_at(c5 + k, PH, 0, "min_no_high");
    end
    tick(31);

    // invalid mode during LOW, then recovery
    c6 = cyc;
    modo = 2'b10;
    exp_at(c6 + 1, PL, 0, "inv_low_off");
    exp_at(c6 + 1, PH, 0, "inv_high_off");
    exp_at(c6 + 3, PL, 0, "inv_idle");
    tick(3);
    c7 = cyc;
    modo = 2'b01;
    exp_at(c7 + 8, PL, 0, "inv_reentry_dt");
    exp_at(c7 + 9, PL, 1, "inv_reentry_low");
    tick(12);

    // enable 1->0->1
    c8 = cyc;
    en = 1'b0;
    exp_at(c8 + 1, PL, 0, "en_off");
    tick(2);
    en = 1'b1;
    exp_at(c8 + 10, PL, 0, "en_reentry_dt");
    exp_at(c8 + 11, PL, 1, "en_reentry_low");
    tick(12);

    // mode change mid-run: new peak visible two cycles after the change
    c9 = cyc;
    q = 17'd0; modo = 2'b00;
    exp_at(c9 + 2, RF, 1920, "mc_ref_m0");
    tick(4);
    modo = 2'b01;
    exp_at(c9 + 5, RF, 1920, "mc_ref_hold");
    exp_at(c9 + 6, RF, 7680, "mc_ref_m1");
    tick(8);

    tick(3);
    n_chk++;
    if (n_inv == 0) n_pass++;
    else $display("FAIL invariant: pwm_h&pwm_l high in %0d cycles, required 0", n_inv);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d checks pending, required 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
